clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Reconfiguration controller for one clk_div instance. Arbitrates divisor-change requests from
//  NUM_REQ requesters (round-robin) and runs a safe change sequence for each granted request:
//  gate output clock, reset divider, load new divisor, settle, ungate.
//  Sits beside clk_div and a downstream clock gate (ICG, not part of this block).
// PARAMETERS
//  NUM_REQ        4  number of requesters (>=1)
//  DIVISOR_SIZE   9  divisor width; must match the clk_div instance
//  RESET_DIVISOR  1  divisor_o value at reset (1 = bypass)
//  GATE_CYCLES    2  clk_i cycles clk_en_o is low before divider reset (>=1)
//  SETTLE_CYCLES  4  clk_i cycles after divider reset release before ungate (>=1)
// PORTS
//  arst_ni     in   1                        async active-low global reset
//  clk_i       in   1                        clock (same clock as clk_div.clk_i)
//  req_i       in   NUM_REQ                  per-requester change request, level
//  div_i       in   NUM_REQ x DIVISOR_SIZE   requested divisor; stable while req_i high
//  gnt_o       out  NUM_REQ                  one-cycle done pulse to the served requester
//  busy_o      out  1                        high whenever FSM is not IDLE
//  divisor_o   out  DIVISOR_SIZE             to clk_div.divisor_i
//  div_arst_no out  1                        to clk_div.arst_ni (active-low)
//  clk_en_o    out  1                        enable for downstream clock gate
// BEHAVIOUR
//  Reset: gnt_o=0, busy_o=0, divisor_o=RESET_DIVISOR, div_arst_no=0, clk_en_o=1, FSM=IDLE,
//   round-robin pointer = requester 0 highest priority. div_arst_no rises at first clk_i edge
//   after arst_ni deassert.
//  All outputs registered. States: IDLE, GATE, DIVRST, SETTLE, DONE.
//  IDLE: any req_i high -> RR arbiter picks winner (priority starts one above last served);
//   latch winner index + div_i[winner]. If latched value == divisor_o -> DONE (no disruption),
//   else -> GATE. Pointer advances only on capture.
//  GATE: clk_en_o=0 for exactly GATE_CYCLES cycles -> DIVRST.
//  DIVRST: div_arst_no=0 for 1 cycle; divisor_o <= latched value -> SETTLE.
//  SETTLE: div_arst_no=1, clk_en_o=0 for SETTLE_CYCLES cycles -> DONE.
//  DONE: gnt_o[idx]=1 for 1 cycle, clk_en_o=1 -> IDLE. Back-to-back requests: next capture
//   occurs in IDLE the cycle after DONE; never two grants within 2 cycles.
//  Latency (capture edge to gnt_o high): unchanged divisor 1 cycle; changed divisor
//   GATE_CYCLES+SETTLE_CYCLES+2 cycles. clk_en_o low for GATE_CYCLES+1+SETTLE_CYCLES cycles.
//  Requester rules: hold req_i until gnt_o; drop req_i in the gnt_o cycle or re-request.
//   req_i dropped before capture -> ignored. After capture, sequence completes and gnt_o fires
//   even if req_i dropped. req_i/div_i changes during busy_o are ignored until IDLE.
//  Divisor 0 or 1 is legal (clk_div bypass); loaded like any other value.
//  Phase counter width $clog2(max(GATE_CYCLES,SETTLE_CYCLES)+1); counter reloads per state,
//   no wrap beyond terminal count.
//  arst_ni assert mid-sequence: all outputs return to reset values immediately; captured
//   request is dropped without gnt_o; requester must re-request.
// STRUCTURE
//  Package clk_div_pkg: state enum clk_div_ctrl_state_e, default param constants.
//  Sub-module clk_div_rr_arb: NUM_REQ round-robin arbiter (req vector, advance strobe ->
//   one-hot grant + index); one combinational pick, registered pointer.
//  Top: FSM, phase counter, latched divisor/index, output registers.
// TESTING
//  Reset release, no req -> divisor_o=1, clk_en_o=1, div_arst_no 0->1 after 1 edge, busy_o=0.
//  req_i=0001, div_i[0]=6 -> clk_en_o low 7 cycles, div_arst_no low 1 cycle, divisor_o=6,
//   gnt_o=0001 exactly 8 cycles after capture; clk_div output period = 6 clk_i.
//  req_i=0001, div_i[0]=divisor_o -> gnt_o[0] next cycle, clk_en_o and div_arst_no never drop.
//  req_i=1111 held, distinct divisors -> grants in order 0,1,2,3,0; each divisor_o applied in turn.
//  Changed-divisor sequence, arst_ni low during SETTLE -> all outputs reset values, no gnt_o;
//   after release new req served normally.
//  req_i pulse 1 cycle while busy_o=1 -> never granted; sampled req in IDLE always served.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Purpose: shared types and default parameters for the clk_div reconfiguration controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_DIVRST,
        ST_SETTLE,
        ST_DONE
    } clk_div_ctrl_state_e;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_DIVISOR_SIZE  = 9;
    localparam int DEF_RESET_DIVISOR = 1;
    localparam int DEF_GATE_CYCLES   = 2;
    localparam int DEF_SETTLE_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_div_rr_arb.sv
// Purpose: round-robin pick among NUM_REQ level requests; pointer moves one past the winner on adv.
// Latency: combinational grant; pointer updates on the clk_i edge where adv is high.
// Backpressure: none; the caller decides when a pick is consumed via adv.
// Ports: clk_i/arst_ni clock and async active-low reset; req request vector; adv consume strobe;
//        gnt one-hot winner; idx binary winner (both zero when req is empty).
module clk_div_rr_arb
    import clk_div_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    // ptr_q holds the index that currently has highest priority.
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr_q) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Purpose: serialises divisor changes for one clk_div: gate, reset divider, load, settle, ungate.
// Latency: capture->gnt 1 cycle if divisor unchanged, else GATE_CYCLES+SETTLE_CYCLES+2 cycles.
// Backpressure: one request in flight; others wait (level req) until the FSM is back in IDLE.
// Ports: req_i/div_i requests with divisors; gnt_o done pulse; busy_o not-idle; divisor_o,
//        div_arst_no drive clk_div; clk_en_o drives the downstream clock gate. All outputs registered.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int DIVISOR_SIZE  = DEF_DIVISOR_SIZE,
    parameter int RESET_DIVISOR = DEF_RESET_DIVISOR,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                                 arst_ni,
    input  logic                                 clk_i,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ-1:0][DIVISOR_SIZE-1:0] div_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    output logic                                 busy_o,
    output logic [DIVISOR_SIZE-1:0]              divisor_o,
    output logic                                 div_arst_no,
    output logic                                 clk_en_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(max_int(GATE_CYCLES, SETTLE_CYCLES) + 1);

    clk_div_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVISOR_SIZE-1:0] div_q, div_d;
    // The winner is held one-hot so the grant pulse needs no decode.
    logic [NUM_REQ-1:0]      sel_q, sel_d;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_adv;

    clk_div_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .req     (req_i),
        .adv     (arb_adv),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    // Phase counter is loaded with N-1 on state entry and exits the state at zero,
    // so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sel_d   = sel_q;
        arb_adv = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    arb_adv = 1'b1;
                    sel_d   = arb_gnt;
                    div_d   = div_i[arb_idx];
                    if (div_i[arb_idx] == divisor_o) begin
                        // Same divisor already running: acknowledge without touching the clock.
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GATE;
                        cnt_d   = CNT_W'(GATE_CYCLES - 1);
                    end
                end
            end
            ST_GATE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DIVRST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIVRST: begin
                state_d = ST_SETTLE;
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each output matches the state it belongs to.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_q       <= DIVISOR_SIZE'(RESET_DIVISOR);
            sel_q       <= '0;
            gnt_o       <= '0;
            busy_o      <= 1'b0;
            divisor_o   <= DIVISOR_SIZE'(RESET_DIVISOR);
            div_arst_no <= 1'b0;
            clk_en_o    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            sel_q       <= sel_d;
            gnt_o       <= (state_d == ST_DONE) ? sel_d : '0;
            busy_o      <= (state_d != ST_IDLE);
            div_arst_no <= (state_d != ST_DIVRST);
            clk_en_o    <= !(state_d inside {ST_GATE, ST_DIVRST, ST_SETTLE});
            if (state_d == ST_DIVRST) begin
                divisor_o <= div_q;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Purpose: directed table-driven bench for clk_div_ctrl plus hand sequences for reset and pulses.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_div_ctrl;

    logic            clk;
    logic            arst_ni;
    logic [3:0]      req;
    logic [3:0][8:0] div;
    logic [3:0]      gnt_o;
    logic            busy_o;
    logic [8:0]      divisor_o;
    logic            div_arst_no;
    logic            clk_en_o;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_ctrl dut (
        .arst_ni     (arst_ni),
        .clk_i       (clk),
        .req_i       (req),
        .div_i       (div),
        .gnt_o       (gnt_o),
        .busy_o      (busy_o),
        .divisor_o   (divisor_o),
        .div_arst_no (div_arst_no),
        .clk_en_o    (clk_en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      req;
        logic [3:0][8:0] div;
        bit              held;     // previous row kept requesting: expect back-to-back capture
        bit              drop;     // drop all requests in the grant cycle
        int              exp_idx;
        int              exp_lat;
        int              exp_div;
        int              exp_en_low;
        int              exp_arst_low;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic [3:0] r, input int d0, input int d1, input int d2,
                                input int d3, input bit held, input bit drop, input int idx,
                                input int lat, input int dv, input int enl, input int arl);
        vec_t v;
        v.req          = r;
        v.div[0]       = 9'(d0);
        v.div[1]       = 9'(d1);
        v.div[2]       = 9'(d2);
        v.div[3]       = 9'(d3);
        v.held         = held;
        v.drop         = drop;
        v.exp_idx      = idx;
        v.exp_lat      = lat;
        v.exp_div      = dv;
        v.exp_en_low   = enl;
        v.exp_arst_low = arl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v, input int row);
        int wait_n;
        int k;
        int en_low;
        int arst_low;
        req = v.req;
        div = v.div;
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
        end while (!busy_o && wait_n < 20);
        chk($sformatf("r%0d_capture", row), int'(busy_o), 1);
        if (v.held) chk($sformatf("r%0d_gap", row), wait_n, 2);
        k = 1;
        en_low = 0;
        arst_low = 0;
        while (gnt_o == 4'b0 && k < 40) begin
            if (!clk_en_o) en_low++;
            if (!div_arst_no) arst_low++;
            @(negedge clk);
            k++;
        end
        if (!clk_en_o) en_low++;
        if (!div_arst_no) arst_low++;
        chk($sformatf("r%0d_gnt", row), int'(gnt_o), 1 << v.exp_idx);
        chk($sformatf("r%0d_lat", row), k, v.exp_lat);
        chk($sformatf("r%0d_divisor", row), int'(divisor_o), v.exp_div);
        chk($sformatf("r%0d_en_low", row), en_low, v.exp_en_low);
        chk($sformatf("r%0d_arst_low", row), arst_low, v.exp_arst_low);
        chk($sformatf("r%0d_busy_at_gnt", row), int'(busy_o), 1);
        if (v.drop) req = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, int'(gnt_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_divisor"}, int'(divisor_o), 1);
        chk({tag, "_div_arst_n"}, int'(div_arst_no), 0);
        chk({tag, "_clk_en"}, int'(clk_en_o), 1);
    endtask

    initial begin
        int k;
        int bad_gnt;
        int busy_n;

        // Each row carries state (divisor_o, pointer) from the previous one.
        tbl[0]  = mk(4'b1111, 3, 5, 9, 200, 0, 0, 0, 8, 3,   7, 1);
        tbl[1]  = mk(4'b1111, 3, 5, 9, 200, 1, 0, 1, 8, 5,   7, 1);
        tbl[2]  = mk(4'b1111, 3, 5, 9, 200, 1, 0, 2, 8, 9,   7, 1);
        tbl[3]  = mk(4'b1111, 3, 5, 9, 200, 1, 0, 3, 8, 200, 7, 1);
        tbl[4]  = mk(4'b1111, 3, 5, 9, 200, 1, 1, 0, 8, 3,   7, 1);
        tbl[5]  = mk(4'b0001, 6, 0, 0, 0,   0, 1, 0, 8, 6,   7, 1);
        tbl[6]  = mk(4'b0001, 6, 0, 0, 0,   0, 1, 0, 1, 6,   0, 0);
        tbl[7]  = mk(4'b0100, 0, 0, 0, 0,   0, 1, 2, 8, 0,   7, 1);
        tbl[8]  = mk(4'b1000, 0, 0, 0, 1,   0, 1, 3, 8, 1,   7, 1);
        tbl[9]  = mk(4'b0110, 0, 1, 1, 0,   0, 1, 1, 1, 1,   0, 0);
        tbl[10] = mk(4'b0110, 0, 1, 1, 0,   0, 1, 2, 1, 1,   0, 0);

        req = '0;
        div = '0;
        arst_ni = 1'b0;

        // Reset values, then div_arst_no rises on the first edge after release.
        @(negedge clk);
        chk_reset_vals("rst");
        arst_ni = 1'b1;
        #1;
        chk("rst_rel_div_arst_n_pre", int'(div_arst_no), 0);
        @(negedge clk);
        chk("rst_rel_div_arst_n_post", int'(div_arst_no), 1);
        chk("rst_rel_busy", int'(busy_o), 0);
        chk("rst_rel_divisor", int'(divisor_o), 1);
        chk("rst_rel_clk_en", int'(clk_en_o), 1);

        for (int r = 0; r < 11; r++) begin
            run_row(tbl[r], r);
        end

        // Reset asserted during SETTLE of a changed-divisor sequence.
        req = 4'b0001;
        div[0] = 9'd7;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!busy_o && k < 20);
        repeat (4) @(negedge clk);
        chk("arst_mid_in_settle_div_arst_n", int'(div_arst_no), 1);
        chk("arst_mid_in_settle_clk_en", int'(clk_en_o), 0);
        arst_ni = 1'b0;
        req = '0;
        #1;
        chk_reset_vals("arst_mid");
        repeat (2) @(negedge clk);
        arst_ni = 1'b1;
        bad_gnt = 0;
        busy_n = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt_o != 4'b0) bad_gnt++;
            if (busy_o) busy_n++;
        end
        chk("arst_no_gnt", bad_gnt, 0);
        chk("arst_idle", busy_n, 0);
        run_row(mk(4'b0010, 0, 7, 0, 0, 0, 1, 1, 8, 7, 7, 1), 11);

        // Captured request survives its requester dropping out; a short pulse while busy is ignored.
        req = 4'b0001;
        div[0] = 9'd9;
        div[2] = 9'd4;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!busy_o && k < 20);
        req = 4'b0000;
        k = 1;
        while (gnt_o == 4'b0 && k < 40) begin
            if (k == 2) req = 4'b0100;
            if (k == 3) req = 4'b0000;
            @(negedge clk);
            k++;
        end
        chk("drop_gnt", int'(gnt_o), 1);
        chk("drop_lat", k, 8);
        chk("drop_divisor", int'(divisor_o), 9);
        bad_gnt = 0;
        busy_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt_o != 4'b0) bad_gnt++;
            if (busy_o) busy_n++;
        end
        chk("pulse_no_gnt", bad_gnt, 0);
        chk("pulse_no_busy", busy_n, 0);
        chk("pulse_divisor_kept", int'(divisor_o), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
